// File: rtl/instr_arbiter.sv
// Shared instruction store with a round-robin fetch arbiter for NSM state machines.
// Host writes take the whole cycle. A fetched word lands in the requester's held slot one cycle after its grant.
module instr_arbiter #(
    parameter int NSM = 4,
    parameter int AW  = 5,
    parameter int DW  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DW-1:0]     wr_data,
    input  logic [NSM-1:0]    req,
    input  logic [NSM*AW-1:0] pc,
    output logic [NSM*DW-1:0] instr,
    output logic [NSM-1:0]    valid,
    output logic              stall
);

    localparam int PW    = (NSM > 1) ? $clog2(NSM) : 1;
    localparam int DEPTH = 1 << AW;

    logic [DEPTH-1:0][DW-1:0] mem_q, mem_d;
    logic [NSM-1:0][DW-1:0]   instr_q, instr_d;
    logic [NSM-1:0]           valid_q, valid_d;
    logic [PW-1:0]            ptr_q, ptr_d;

    logic [NSM-1:0][AW-1:0]   pc_v;
    logic [NSM-1:0]           gnt;
    logic                     gnt_any;
    logic [PW-1:0]            gnt_idx;
    logic [PW:0]              scan;
    logic [PW:0]              ptr_nxt;
    logic [AW-1:0]            rd_addr;
    logic [DW-1:0]            rd_data;

    assign pc_v  = pc;
    assign stall = wr_en;
    assign instr = instr_q;
    assign valid = valid_q;

    // Round-robin scan starting at ptr; a host write suppresses every grant.
    always_comb begin
        gnt     = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        scan    = '0;
        if (!wr_en) begin
            for (int k = 0; k < NSM; k++) begin
                scan = {1'b0, ptr_q} + (PW+1)'(k);
                if (scan >= (PW+1)'(NSM))
                    scan = scan - (PW+1)'(NSM);
                if (!gnt_any && req[scan[PW-1:0]]) begin
                    gnt_any                = 1'b1;
                    gnt_idx                = scan[PW-1:0];
                    gnt[scan[PW-1:0]]      = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ptr_nxt = {1'b0, gnt_idx} + 1'b1;
        ptr_d   = ptr_q;
        if (gnt_any)
            ptr_d = (ptr_nxt == (PW+1)'(NSM)) ? '0 : ptr_nxt[PW-1:0];
    end

    // Writes and fetches are mutually exclusive, so the read never sees a same-cycle write.
    assign rd_addr = pc_v[gnt_idx];
    assign rd_data = mem_q[rd_addr];

    always_comb begin
        mem_d = mem_q;
        if (wr_en)
            mem_d[wr_addr] = wr_data;
    end

    assign valid_d = gnt;

    for (genvar i = 0; i < NSM; i++) begin : g_slot
        always_comb begin
            instr_d[i] = instr_q[i];
            if (gnt[i])
                instr_d[i] = rd_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q   <= '0;
            instr_q <= '0;
            valid_q <= '0;
            ptr_q   <= '0;
        end else begin
            mem_q   <= mem_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_instr_arbiter.sv
// Directed bench for instr_arbiter: write/read, rotation, host priority, withdrawal, async reset.
module tb_instr_arbiter;

    localparam int NSM = 4;
    localparam int AW  = 5;
    localparam int DW  = 16;

    logic              clk;
    logic              reset;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic [NSM-1:0]    req;
    logic [NSM*AW-1:0] pc;
    logic [NSM*DW-1:0] instr;
    logic [NSM-1:0]    valid;
    logic              stall;

    int n_chk  = 0;
    int n_fail = 0;

    instr_arbiter #(.NSM(NSM), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .req(req), .pc(pc), .instr(instr), .valid(valid), .stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pc(input int i, input logic [AW-1:0] a);
        pc[i*AW +: AW] = a;
    endtask

    task automatic host_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    function automatic logic [DW-1:0] slot(input int i);
        return instr[i*DW +: DW];
    endfunction

    logic [DW-1:0] rr_word [4];

    initial begin
        reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; req = '0; pc = '0;
        rr_word[0] = 16'hA000; rr_word[1] = 16'hB111; rr_word[2] = 16'hC222; rr_word[3] = 16'hD333;
        tick(); tick();
        chk("reset_valid", 64'(valid), 64'h0);
        chk("reset_instr", 64'(instr), 64'h0);
        reset = 1'b1;
        tick();

        // Write then fetch by machine 0
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 16'hE001;
        #1 chk("stall_hi", 64'(stall), 64'h1);
        tick();
        wr_en = 1'b0;
        #1 chk("stall_lo", 64'(stall), 64'h0);
        req = 4'b0001; set_pc(0, 5'd3);
        tick();
        chk("wr_rd_valid", 64'(valid), 64'h1);
        chk("wr_rd_instr", 64'(instr), 64'h0000_0000_0000_E001);
        req = '0;
        tick();
        chk("valid_clears", 64'(valid), 64'h0);
        chk("instr_holds", 64'(instr), 64'h0000_0000_0000_E001);

        // ptr is 1; lone grant to machine 3 wraps it back to 0
        req = 4'b1000; set_pc(3, 5'd3);
        tick();
        chk("m3_valid", 64'(valid), 64'h8);
        chk("m3_instr", 64'(slot(3)), 64'hE001);
        req = '0;

        // Round-robin rotation from ptr=0
        for (int i = 0; i < 4; i++) host_wr(5'(10 + i), rr_word[i]);
        for (int i = 0; i < 4; i++) set_pc(i, 5'(10 + i));
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("rr_valid", 64'(valid), 64'(4'b0001 << (n % 4)));
            chk("rr_instr", 64'(slot(n % 4)), 64'(rr_word[n % 4]));
        end
        req = '0;
        tick();
        chk("rr_idle", 64'(valid), 64'h0);

        // Host priority: ptr=1, req=0110 held across two write cycles
        req = 4'b0110; set_pc(1, 5'd20); set_pc(2, 5'd21);
        wr_en = 1'b1; wr_addr = 5'd20; wr_data = 16'h5555;
        #1 chk("hp_stall1", 64'(stall), 64'h1);
        tick();
        chk("hp_valid1", 64'(valid), 64'h0);
        wr_addr = 5'd21; wr_data = 16'h6666;
        #1 chk("hp_stall2", 64'(stall), 64'h1);
        tick();
        chk("hp_valid2", 64'(valid), 64'h0);
        wr_en = 1'b0;
        tick();
        chk("hp_first", 64'(valid), 64'h2);
        chk("hp_first_w", 64'(slot(1)), 64'h5555);
        tick();
        chk("hp_second", 64'(valid), 64'h4);
        chk("hp_second_w", 64'(slot(2)), 64'h6666);
        req = '0;

        // Write-then-read coherency, ptr=3
        host_wr(5'd7, 16'h1234);
        req = 4'b0100; set_pc(2, 5'd7);
        tick();
        chk("coh_valid", 64'(valid), 64'h4);
        chk("coh_instr", 64'(slot(2)), 64'h1234);
        req = '0;

        // Withdrawal: park ptr at 0 via machine 3, then 3 loses to 0 and drops
        req = 4'b1000; set_pc(3, 5'd3);
        tick();
        chk("wd_park", 64'(valid), 64'h8);
        req = 4'b1001; set_pc(0, 5'd10); set_pc(3, 5'd11);
        tick();
        chk("wd_m0", 64'(valid), 64'h1);
        req = '0;
        tick();
        chk("wd_none", 64'(valid), 64'h0);
        tick();
        chk("wd_none2", 64'(valid), 64'h0);
        chk("wd_hold3", 64'(slot(3)), 64'hE001);

        // Async reset while valid=0100
        req = 4'b0100; set_pc(2, 5'd7);
        tick();
        chk("ar_pre", 64'(valid), 64'h4);
        req = 4'b1010; set_pc(1, 5'd7); set_pc(3, 5'd3);
        #2 reset = 1'b0;
        #1;
        chk("ar_valid", 64'(valid), 64'h0);
        chk("ar_instr", 64'(instr), 64'h0);
        #3 reset = 1'b1;
        tick();
        chk("ar_first", 64'(valid), 64'h2);
        chk("ar_mem_clr", 64'(slot(1)), 64'h0);
        tick();
        chk("ar_second", 64'(valid), 64'h8);
        req = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_arbiter.md
# instr_arbiter

Shared instruction-memory front end for the PIO block. Owns the single 32 x 16-bit instruction store and arbitrates one read per cycle among up to NSM state machines with a round-robin scheduler. It also accepts host program writes, which take priority over fetches. Each machine receives its fetched instruction word through its own held output register and a one-cycle valid strobe.

## Interface
Parameters:
- NSM, 4: number of requesting state machines (2..8).
- AW, 5: instruction address width (memory depth 2^AW).
- DW, 16: instruction width.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- wr_en  in  1  host write strobe.
- wr_addr  in  AW  host write address.
- wr_data  in  DW  host write data.
- req  in  NSM  per-machine fetch request; level, held until served.
- pc  in  NSM*AW  per-machine fetch address; machine i occupies bits [i*AW +: AW].
- instr  out  NSM*DW  per-machine fetched word; machine i occupies bits [i*DW +: DW]; held between fetches.
- valid  out  NSM  one-cycle strobe; instr slice i was updated this cycle.
- stall  out  1  high in the cycle a host write blocks all fetches (combinational, equals wr_en).

## Operation
- **Memory**
  - 2^AW x DW register array, cleared to 0 on reset.
  - Write port: wr_en=1 writes wr_data to wr_addr at the clock edge.
- **Host priority**
  - When wr_en=1, no grant is issued that cycle.
  - The round-robin pointer does not move.
  - req stays pending.
- **Arbitration** (when wr_en=0)
  - Grant goes to the first i with req[i]=1, scanning ptr, ptr+1, … mod NSM.
  - On a grant to g, ptr <= (g+1) mod NSM.
  - With no requests, ptr is unchanged.
- **Read**
  - The granted machine's pc slice addresses the memory.
  - At the edge, instr slice g <= mem[pc_g] and valid <= one-hot(g).
  - All other instr slices hold.
  - valid clears the next cycle unless the same machine is granted again.
- **Request handshake**
  - A requester samples valid[i]=1, then must deassert req[i] or change pc in that same cycle if it does not want a repeat fetch.
  - Otherwise req[i] is re-arbitrated normally.
- **Withdrawal**: a req dropped before grant produces no fetch and no valid.
- **Fairness**: with wr_en=0, any held request is granted within NSM cycles.
- **Write/read ordering**
  - A write and a fetch never occur in the same cycle.
  - A fetch in the cycle after a write to the same address returns the new data.
- **Out-of-range**: pc is AW bits wide, so every address is legal; no wrap handling is needed.

## Timing
- **Reset values**
  - instr = 0, valid = 0, ptr = 0, memory = 0.
  - stall follows wr_en combinationally.
- **Reset mid-operation**
  - All outputs clear asynchronously.
  - Any in-flight fetch is lost; requesters must re-request after reset deasserts.
- **Latency**: req[i] with a grant in cycle N gives valid[i]=1 and new instr slice i in cycle N+1.
- **Back-to-back grants**
  - The same machine may be granted in consecutive cycles only if it is the sole requester.
  - With k requesters, each is served every k cycles.
- **Throughput**: one fetch per cycle maximum, zero fetches in write cycles.
- **Simultaneous events**: wr_en and all req high means the write wins and ptr holds; the next cycle grants the machine at ptr.

## Test plan
- **Reset and write/read**
  - Reset, write mem[3]=16'hE001.
  - Machine 0 req with pc=3.
  - Expect valid=4'b0001 one cycle after grant, instr[15:0]=16'hE001, other slices 0.
- **Round-robin rotation**
  - All 4 req held high with distinct pcs and ptr=0.
  - Expect valid sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles, each slice carrying its own word.
- **Host priority**
  - Hold req=4'b0110 and assert wr_en for 2 cycles.
  - Expect stall=1 and valid=0 during the write and one cycle after it.
  - Then expect grant order 1 then 2, with ptr unchanged by the writes.
- **Write-then-read coherency**
  - Write mem[7]=16'h1234, next cycle machine 2 reads pc=7.
  - Expect instr slice 2 = 16'h1234.
- **Withdrawal and hold**
  - Machine 3 req for 1 cycle while machine 0 is granted; machine 3 then drops req.
  - Expect no valid[3].
  - Expect instr slice 3 to retain its previous value.
- **Async reset mid-stream**
  - Assert reset low between clock edges while valid=0100.
  - Expect valid=0 and all instr slices 0 immediately.
  - After release, first grant goes to the lowest-index requester.
